// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_PAUSE = 2'd3
    } seq_state_t;

    localparam logic [19:0] NOP_DEFAULT = 20'h00000;

    // Hold counter width; covers CPI values up to 15.
    localparam int CPI_W = 4;

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write port, asynchronous read port, no reset.
module prog_ram #(
    parameter int AW = 4,
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_sequencer.sv
// Instruction sequencer feeding simple_cpu: presents each program word for CPI cycles.
// Optional single-step support is built when SEQ_STEP_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for start; host loads allowed
// ST_RUN   | word RAM[pc] on instr_out, hold counter running
// ST_PAUSE | step mode only: NOP driven until a step pulse
// ST_DONE  | one-cycle completion pulse, then back to idle
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     PC_BITS     = 4,
    parameter int                     CPI         = 3,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    input  logic [PC_BITS:0]       prog_len,
`ifdef SEQ_STEP_EN
    input  logic                   step_mode,
    input  logic                   step,
`endif
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic                   load_err
);

    localparam logic [PC_BITS:0]   LEN_MAX   = (PC_BITS + 1)'(1 << PC_BITS);
    localparam logic [PC_BITS:0]   LEN_ONE   = (PC_BITS + 1)'(1);
    localparam logic [CPI_W-1:0]   HOLD_LAST = CPI_W'(CPI - 1);

    seq_state_t             state, state_nxt;
    logic [CPI_W-1:0]       hold_cnt, hold_nxt;
    logic [PC_BITS-1:0]     pc_nxt, rd_addr;
    logic [PC_BITS:0]       len, len_nxt;
    logic [INSTR_WIDTH-1:0] instr_nxt, rd_data, fetch_word;
    logic                   ram_we, last_instr, hold_end, go_next;
    logic                   step_mode_i, step_i;

`ifdef SEQ_STEP_EN
    assign step_mode_i = step_mode;
    assign step_i      = step;
`else
    assign step_mode_i = 1'b0;
    assign step_i      = 1'b0;
`endif

    assign ram_we     = load_en && (state == ST_IDLE);
    assign rd_addr    = (state == ST_IDLE) ? '0 : pc + 1'b1;
    // A write landing on the word being fetched this cycle must be seen immediately.
    assign fetch_word = (ram_we && (load_addr == rd_addr)) ? load_data : rd_data;
    assign last_instr = ({1'b0, pc} == (len - LEN_ONE));
    assign hold_end   = (hold_cnt == HOLD_LAST);

    prog_ram #(.AW(PC_BITS), .DW(INSTR_WIDTH)) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        pc_nxt    = pc;
        len_nxt   = len;
        instr_nxt = instr_out;
        go_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (prog_len == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        len_nxt   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                        pc_nxt    = '0;
                        hold_nxt  = '0;
                        instr_nxt = fetch_word;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!hold_end) begin
                    hold_nxt = hold_cnt + 1'b1;
                end else if (step_mode_i) begin
                    hold_nxt  = '0;
                    instr_nxt = NOP_INSTR;
                    state_nxt = ST_PAUSE;
                end else begin
                    go_next = 1'b1;
                end
            end
            ST_PAUSE: go_next = step_i;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        if (go_next) begin
            hold_nxt = '0;
            if (last_instr) begin
                instr_nxt = NOP_INSTR;
                state_nxt = ST_DONE;
            end else begin
                pc_nxt    = pc + 1'b1;
                instr_nxt = fetch_word;
                state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            pc        <= '0;
            len       <= '0;
            instr_out <= NOP_INSTR;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            pc        <= pc_nxt;
            len       <= len_nxt;
            instr_out <= instr_nxt;
            load_err  <= load_en && (state != ST_IDLE);
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_PAUSE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer against a per-cycle trace model.
module tb_prog_sequencer;

    localparam int          IW    = 20;
    localparam int          PB    = 4;
    localparam int          CPI   = 3;
    localparam int          DEPTH = 16;
    localparam logic [19:0] NOP   = 20'h00000;

    logic          clk = 1'b0;
    logic          rst, load_en, start, step_mode, step;
    logic [PB-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic [PB:0]   prog_len;
    logic [IW-1:0] instr_out;
    logic [PB-1:0] pc;
    logic          busy, done, load_err;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] ref_ram [DEPTH];

    typedef struct {
        logic [19:0] instr;
        int          pc;
        bit          busy;
        bit          done;
    } exp_t;
    exp_t expq[$];

    prog_sequencer #(.INSTR_WIDTH(IW), .PC_BITS(PB), .CPI(CPI), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .prog_len  (prog_len),
`ifdef SEQ_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .instr_out (instr_out),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input int a, input logic [19:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a[PB-1:0];
        load_data = d;
        ref_ram[a] = d;
        @(negedge clk);
        load_en = 1'b0;
        check_val("idle_load_err", {31'b0, load_err}, 32'd0);
    endtask

    // Runs one program and compares every cycle from start+1 until back in idle.
    task automatic run_prog(input int n, input bit load0, input bit disturb);
        int eff;
        int hit;
        bit prev_err;
        eff = (n > DEPTH) ? DEPTH : n;
        @(negedge clk);
        start    = 1'b1;
        prog_len = n[PB:0];
        if (load0) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_data = IW'($urandom);
            ref_ram[0] = load_data;
        end
        expq.delete();
        for (int k = 0; k < eff; k++)
            for (int c = 0; c < CPI; c++)
                expq.push_back('{ref_ram[k], k, 1'b1, 1'b0});
        expq.push_back('{NOP, -1, 1'b0, 1'b1});
        expq.push_back('{NOP, -1, 1'b0, 1'b0});
        hit = disturb ? int'($urandom_range(0, expq.size() - 2)) : -1;
        prev_err = 1'b0;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge clk);
            if (i == 0 || i - 1 == hit) begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            check_val("instr", {12'b0, instr_out}, {12'b0, expq[i].instr});
            check_val("busy", {31'b0, busy}, {31'b0, expq[i].busy});
            check_val("done", {31'b0, done}, {31'b0, expq[i].done});
            check_val("load_err", {31'b0, load_err}, {31'b0, prev_err});
            if (expq[i].pc >= 0) check_val("pc", {28'b0, pc}, expq[i].pc);
            prev_err = (i == hit);
            if (i == hit) begin
                load_en   = 1'b1;
                load_addr = PB'($urandom);
                load_data = IW'($urandom);
                start     = 1'b1;
                prog_len  = (PB + 1)'($urandom);
            end
        end
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        load_addr = '0; load_data = '0; prog_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_instr", {12'b0, instr_out}, {12'b0, NOP});
        check_val("rst_pc", {28'b0, pc}, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_load_err", {31'b0, load_err}, 32'd0);
        rst = 1'b0;

        load_word(0, 20'h11111);
        load_word(1, 20'h22222);
        load_word(2, 20'h33333);
        run_prog(3, 1'b0, 1'b0);

        for (int a = 0; a < DEPTH; a++) load_word(a, IW'($urandom));
        run_prog(0, 1'b0, 1'b1);
        run_prog(31, 1'b0, 1'b1);
        run_prog(16, 1'b1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            load_word(int'($urandom_range(0, DEPTH - 1)), IW'($urandom));
            run_prog(int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
        end

        // Reset asserted in the fourth cycle of a run, then the program is rerun.
        @(negedge clk);
        start = 1'b1; prog_len = 5'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_busy", {31'b0, busy}, 32'd0);
        check_val("mid_rst_instr", {12'b0, instr_out}, {12'b0, NOP});
        check_val("mid_rst_pc", {28'b0, pc}, 32'd0);
        check_val("mid_rst_done", {31'b0, done}, 32'd0);
        run_prog(5, 1'b0, 1'b0);

`ifdef SEQ_STEP_EN
        step_mode = 1'b1;
        @(negedge clk);
        start = 1'b1; prog_len = 5'd3;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < CPI; c++) begin
                @(negedge clk);
                start = 1'b0; step = 1'b0;
                check_val("step_instr", {12'b0, instr_out}, {12'b0, ref_ram[k]});
                check_val("step_pc", {28'b0, pc}, k);
                check_val("step_busy", {31'b0, busy}, 32'd1);
            end
            repeat (2) begin
                @(negedge clk);
                check_val("pause_instr", {12'b0, instr_out}, {12'b0, NOP});
                check_val("pause_busy", {31'b0, busy}, 32'd1);
                check_val("pause_done", {31'b0, done}, 32'd0);
            end
            step = 1'b1;
        end
        @(negedge clk);
        step = 1'b0;
        check_val("step_done", {31'b0, done}, 32'd1);
        check_val("step_done_busy", {31'b0, busy}, 32'd0);
        step_mode = 1'b0;
        run_prog(3, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Instruction sequencer sitting in front of `simple_cpu`. It holds a small program RAM loaded by a host, and on a start pulse presents each stored 20-bit instruction on the CPU's `instruction` input for a fixed number of clock cycles. It then advances through the program, and reports completion. It owns CPU pacing; the CPU datapath itself is untouched.

## Interface
Parameters:
- `INSTR_WIDTH`, 20: instruction width; matches the CPU instruction bus.
- `PC_BITS`, 4: program address width; program depth = 2**PC_BITS.
- `CPI`, 3: clock cycles each instruction is held on `instr_out`; legal range 1..15.
- `NOP_INSTR`, 20'h00000: value driven on `instr_out` when not running.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous active-high reset.
- `load_en` in 1: write `load_data` to `load_addr` this cycle.
- `load_addr` in PC_BITS: program RAM write address.
- `load_data` in INSTR_WIDTH: program word.
- `start` in 1: single-cycle pulse that begins execution.
- `prog_len` in PC_BITS+1: number of instructions to run; sampled with `start`.
- `instr_out` out INSTR_WIDTH: to CPU `instruction`; registered.
- `pc` out PC_BITS: index of instruction currently on `instr_out`.
- `busy` out 1: high while executing.
- `done` out 1: one-cycle pulse after the last instruction completes.
- `load_err` out 1: one-cycle pulse when a load is dropped.

## Operation
- FSM states: IDLE, RUN, DONE. With SEQ_STEP_EN, the FSM also has a PAUSE state.
- IDLE: `load_en` writes RAM. `start` with `prog_len`=0 goes to DONE. `start` with `prog_len`>0 latches `len` = min(`prog_len`, 2**PC_BITS), sets `pc`=0, loads `instr_out`=RAM[0], clears the hold counter, and goes to RUN.
- RUN: the hold counter counts 0..CPI-1.
  - At CPI-1, if `pc`=`len`-1, go to DONE.
  - Otherwise, `pc`+1, `instr_out`=RAM[`pc`+1], and the counter returns to 0.
- DONE: `done`=1, `busy`=0, `instr_out`=NOP_INSTR. Return to IDLE next cycle.
- Loads: `load_en` outside IDLE is ignored (RAM unchanged) and pulses `load_err` the following cycle.
- `start` outside IDLE is ignored.
- `load_en` and `start` in the same IDLE cycle: the write happens first. If it targets address 0, the new word is what RUN presents at `pc`=0.
- `pc` arithmetic is PC_BITS wide. Because `len` is clamped, `pc` never wraps.
- Reset mid-run: next cycle the FSM is in IDLE, outputs are at reset values, and RAM contents are preserved.

## Timing
- Reset values:
  - `instr_out`=NOP_INSTR, `pc`=0, `busy`=0, `done`=0, `load_err`=0.
  - FSM=IDLE, hold counter=0.
  - RAM is not reset.
- `start` sampled at edge t with `prog_len`=N>0:
  - Cycles t+1..t+CPI: RAM[0] on `instr_out`, `busy`=1.
  - Cycles t+k·CPI+1..t+(k+1)·CPI: RAM[k].
- `done` is high in cycle t+N·CPI+1; `busy` is low in that same cycle.
- `prog_len`=0: `done` in cycle t+1, `busy` never asserts.
- A RAM write at edge t is readable by a start at edge t+1 or later, and also at edge t per the same-cycle rule above.

## Configuration
- `SEQ_STEP_EN` defined:
  - Adds input ports `step_mode` (1) and `step` (1).
  - With `step_mode`=1, after each instruction's CPI cycles the FSM enters PAUSE and keeps driving `instr_out`=NOP_INSTR with `busy`=1.
  - A `step` pulse in PAUSE presents the next instruction (next cycle), or goes to DONE after the last one.
  - With `step_mode`=0, timing is identical to the non-step build.
- `SEQ_STEP_EN` undefined: no PAUSE state and no step ports.

## Structure
- Shared package `seq_pkg`: FSM state enum (IDLE, RUN, DONE, PAUSE), default NOP_INSTR constant, and the CPI width constant.
- One natural sub-module: `prog_ram`. It has a 2**PC_BITS × INSTR_WIDTH array, a synchronous write port and an asynchronous read port.
- FSM, hold counter and output registers live in `prog_sequencer`.

## Test plan
- Load RAM[0..2] = 20'h11111, 20'h22222, 20'h33333; start with `prog_len`=3, CPI=3 → each word held exactly 3 cycles, `pc` 0,1,2, `done` at cycle t+10, then `instr_out`=NOP.
- Start with `prog_len`=0 → `done` at t+1, `busy` stays 0.
- `prog_len`=31 with PC_BITS=4 → exactly 16 instructions run; `pc` never wraps past 15.
- `load_en` during RUN → `load_err` pulse, RAM unchanged (verified on the next run); `start` during RUN is ignored.
- Assert `rst` at cycle 4 of a run → next cycle `busy`=0, `instr_out`=NOP, `pc`=0; a restart reruns the program from RAM[0].
- `SEQ_STEP_EN`, `step_mode`=1 → after each instruction NOP is held until `step`; three steps complete a 3-instruction program with `done`.
